// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : udp_pkg
// Brief   : Shared header sizes and line-packer state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package udp_pkg;

    localparam int UDP_HDR_BYTES = 8;
    localparam int IP_HDR_BYTES  = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LINE = 3'd1,
        ST_PAD  = 3'd2,
        ST_DROP = 3'd3,
        ST_SYNC = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/udp_line_packer.sv
`default_nettype none
// ============================================================================
// Module  : udp_line_packer
// Brief   : Packs 16-bit pixel pairs into 32-bit tx FIFO words, one UDP line.
// Rev     : 1.0  initial release
// ============================================================================
module udp_line_packer
    import udp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        g_clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_eol,
    output logic        pix_ready,
    input  logic        fifo_afull,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    output logic        frame_sync,
    output logic        line_sync,
    output logic [15:0] line_number,
    output logic [11:0] v_height,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        err_sticky
);

    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] c_h_last  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_h_total = CNT_W'(H_ACTIVE);
    localparam logic [11:0]      c_v_last  = 12'(V_ACTIVE - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [15:0]        r_even;
    logic               r_wr_en;
    logic [31:0]        r_wr_data;
    logic               r_frame_sync;
    logic [11:0]        r_line_cnt;
    logic [11:0]        r_line_number;
    logic               r_err;
    logic               r_sof_pend;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_pad_cnt;
    logic               w_ready;
    logic               w_wr_en_next;
    logic [31:0]        w_wr_data_next;
    logic               w_even_load;
    logic               w_err_set;
    logic               w_sof_set;
    logic               w_sof_clr;
    logic               w_frame_start;
    logic               w_line_inc;
    logic               w_sof_midline;

    // An odd count means an even pixel is half-packed; pad completes that word first.
    assign w_pad_cnt     = r_pix_cnt + (r_pix_cnt[0] ? CNT_W'(1) : CNT_W'(2));
    assign w_sof_midline = pix_sof && (r_pix_cnt != '0);

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_pix_cnt;
        w_ready        = 1'b0;
        w_wr_en_next   = 1'b0;
        w_wr_data_next = 32'h0;
        w_even_load    = 1'b0;
        w_err_set      = 1'b0;
        w_sof_set      = 1'b0;
        w_sof_clr      = 1'b0;
        w_frame_start  = 1'b0;
        w_line_inc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (pix_valid && pix_sof) begin
                    w_even_load   = 1'b1;
                    w_frame_start = 1'b1;
                    w_cnt_next    = CNT_W'(1);
                    if (pix_eol) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_PAD;
                    end else begin
                        w_state_next = ST_LINE;
                    end
                end
            end
            ST_LINE: begin
                w_ready = !fifo_afull && !w_sof_midline;
                if (pix_valid && w_sof_midline) begin
                    w_err_set    = 1'b1;
                    w_sof_set    = 1'b1;
                    w_state_next = ST_PAD;
                end else if (pix_valid && w_ready) begin
                    if (r_pix_cnt[0]) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_data_next = {r_even, pix_data};
                    end else begin
                        w_even_load = 1'b1;
                    end
                    // sof on pixel 0 of a later line restarts the frame
                    w_frame_start = pix_sof;
                    if (r_pix_cnt == c_h_last) begin
                        w_cnt_next = '0;
                        if (pix_eol) begin
                            w_state_next = ST_SYNC;
                        end else begin
                            w_err_set    = 1'b1;
                            w_state_next = ST_DROP;
                        end
                    end else begin
                        w_cnt_next = r_pix_cnt + CNT_W'(1);
                        if (pix_eol) begin
                            w_err_set    = 1'b1;
                            w_state_next = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (!fifo_afull) begin
                    w_wr_en_next   = 1'b1;
                    w_wr_data_next = r_pix_cnt[0] ? {r_even, 16'h0} : 32'h0;
                    w_cnt_next     = w_pad_cnt;
                    if (w_pad_cnt == c_h_total) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_SYNC;
                    end
                end
            end
            ST_DROP: begin
                w_ready = !pix_sof;
                if (pix_valid && pix_sof) begin
                    w_sof_set    = 1'b1;
                    w_state_next = ST_SYNC;
                end else if (pix_valid && pix_eol) begin
                    w_state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (r_sof_pend) begin
                    w_sof_clr    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_line_cnt == c_v_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_line_inc   = 1'b1;
                    w_state_next = ST_LINE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_pix_cnt     <= '0;
            r_even        <= 16'h0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= 32'h0;
            r_frame_sync  <= 1'b0;
            r_line_cnt    <= 12'h0;
            r_line_number <= 12'h0;
            r_err         <= 1'b0;
            r_sof_pend    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pix_cnt    <= w_cnt_next;
            r_wr_en      <= w_wr_en_next;
            r_frame_sync <= w_frame_start;
            if (w_even_load) begin
                r_even <= pix_data;
            end
            if (w_wr_en_next) begin
                r_wr_data <= w_wr_data_next;
            end
            if (w_frame_start) begin
                r_line_cnt <= 12'h0;
            end else if (w_line_inc) begin
                r_line_cnt <= r_line_cnt + 12'h1;
            end
            // Latch the completed line's index on entry to SYNC so it holds afterwards.
            if (w_frame_start) begin
                r_line_number <= 12'h0;
            end else if (w_state_next == ST_SYNC && r_state != ST_SYNC) begin
                r_line_number <= r_line_cnt;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_sof_set) begin
                r_sof_pend <= 1'b1;
            end else if (w_sof_clr) begin
                r_sof_pend <= 1'b0;
            end
        end
    end

    assign pix_ready       = w_ready;
    assign fifo_wr_en      = r_wr_en;
    assign fifo_wr_data    = r_wr_data;
    assign frame_sync      = r_frame_sync;
    assign line_sync       = (r_state == ST_SYNC);
    assign line_number     = {4'h0, r_line_number};
    assign err_sticky      = r_err;
    assign v_height        = 12'(V_ACTIVE);
    assign tx_data_length  = 16'(UDP_HDR_BYTES + 2 * H_ACTIVE);
    assign tx_total_length = 16'(UDP_HDR_BYTES + IP_HDR_BYTES + 2 * H_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_udp_line_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_udp_line_packer
// Brief   : Directed scoreboard bench for udp_line_packer (H=8, V=2).
// Rev     : 1.0  initial release
// ============================================================================
module tb_udp_line_packer;

    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 2;

    logic        g_clk;
    logic        reset_n;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_ready;
    logic        fifo_afull;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        frame_sync;
    logic        line_sync;
    logic [15:0] line_number;
    logic [11:0] v_height;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic        err_sticky;

    udp_line_packer #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) dut (
        .g_clk           (g_clk),
        .reset_n         (reset_n),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_sof         (pix_sof),
        .pix_eol         (pix_eol),
        .pix_ready       (pix_ready),
        .fifo_afull      (fifo_afull),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_wr_data    (fifo_wr_data),
        .frame_sync      (frame_sync),
        .line_sync       (line_sync),
        .line_number     (line_number),
        .v_height        (v_height),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .err_sticky      (err_sticky)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_frames = 0;
    int          bp_left  = 0;
    logic [31:0] wq[$];
    logic [31:0] lq[$];
    logic [31:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every FIFO write and line_sync is matched against the queues.
    always @(negedge g_clk) begin
        if (reset_n) begin
            if (fifo_wr_en) begin
                if (wq.size() > 0) begin
                    mon_exp = wq.pop_front();
                    check("wr_data", fifo_wr_data, mon_exp);
                end else begin
                    check("unexp_write", {31'h0, fifo_wr_en}, 32'h0);
                end
            end
            if (line_sync) begin
                if (lq.size() > 0) begin
                    mon_exp = lq.pop_front();
                    check("line_number", {16'h0, line_number}, mon_exp);
                end else begin
                    check("unexp_line_sync", {31'h0, line_sync}, 32'h0);
                end
            end
            if (frame_sync) n_frames++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge g_clk);
    endtask

    // Holds one pixel until accepted; backpressure cycles must show pix_ready low.
    task automatic send_pix(input logic [15:0] d, input logic sof, input logic eol);
        int   tries = 0;
        logic acc   = 1'b0;
        while (!acc && tries < 50) begin
            pix_valid  = 1'b1;
            pix_data   = d;
            pix_sof    = sof;
            pix_eol    = eol;
            fifo_afull = (bp_left > 0);
            #1;
            acc = pix_ready;
            if (bp_left > 0) begin
                check("bp_ready", {31'h0, pix_ready}, 32'h0);
                bp_left--;
            end
            @(negedge g_clk);
            tries++;
        end
        pix_valid  = 1'b0;
        pix_sof    = 1'b0;
        pix_eol    = 1'b0;
        fifo_afull = 1'b0;
        if (!acc) check("send_timeout", {31'h0, acc}, 32'h1);
    endtask

    task automatic send_line(input logic [15:0] base, input logic sof, input int n, input logic eol_last);
        for (int i = 0; i < n; i++) begin
            send_pix(base + 16'(i), sof && (i == 0), eol_last && (i == n - 1));
        end
    endtask

    task automatic push_norm(input logic [15:0] base);
        for (int i = 0; i < H_ACTIVE / 2; i++) begin
            wq.push_back({base + 16'(2 * i), base + 16'(2 * i + 1)});
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 16'h0;
        pix_sof    = 1'b0;
        pix_eol    = 1'b0;
        fifo_afull = 1'b0;
        idle(2);
        #1;
        check("rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        check("rst_wr_data", fifo_wr_data, 32'h0);
        check("rst_frame_sync", {31'h0, frame_sync}, 32'h0);
        check("rst_line_sync", {31'h0, line_sync}, 32'h0);
        check("rst_line_number", {16'h0, line_number}, 32'h0);
        check("rst_err", {31'h0, err_sticky}, 32'h0);
        check("rst_ready", {31'h0, pix_ready}, 32'h1);
        check("v_height", {20'h0, v_height}, 32'd2);
        check("tx_data_length", {16'h0, tx_data_length}, 32'd24);
        check("tx_total_length", {16'h0, tx_total_length}, 32'd44);
        @(negedge g_clk);
        reset_n = 1'b1;
        idle(2);

        // Nominal two-line frame
        push_norm(16'h0001); lq.push_back(0);
        push_norm(16'h0011); lq.push_back(1);
        send_line(16'h0001, 1'b1, 8, 1'b1);
        send_line(16'h0011, 1'b0, 8, 1'b1);
        idle(6);
        check("nom_frames", n_frames, 32'd1);
        check("nom_drained", wq.size(), 32'd0);
        check("nom_idle_ready", {31'h0, pix_ready}, 32'h1);
        check("nom_err", {31'h0, err_sticky}, 32'h0);

        // Backpressure for 5 cycles in the middle of line 0
        push_norm(16'h0021); lq.push_back(0);
        push_norm(16'h0031); lq.push_back(1);
        send_line(16'h0021, 1'b1, 4, 1'b0);
        bp_left = 5;
        send_line(16'h0025, 1'b0, 4, 1'b1);
        send_line(16'h0031, 1'b0, 8, 1'b1);
        idle(6);
        check("bp_consumed", bp_left, 32'd0);
        check("bp_frames", n_frames, 32'd2);
        check("bp_drained", wq.size(), 32'd0);
        check("bp_err", {31'h0, err_sticky}, 32'h0);

        // Short line: eol on pixel 3, padded with two zero words
        wq.push_back(32'h0041_0042); wq.push_back(32'h0043_0044);
        wq.push_back(32'h0); wq.push_back(32'h0); lq.push_back(0);
        push_norm(16'h0051); lq.push_back(1);
        send_line(16'h0041, 1'b1, 4, 1'b1);
        send_line(16'h0051, 1'b0, 8, 1'b1);
        idle(6);
        check("short_err", {31'h0, err_sticky}, 32'h1);
        check("short_frames", n_frames, 32'd3);
        check("short_drained", wq.size(), 32'd0);

        // Long line: 11 pixels, last three dropped
        push_norm(16'h0061); lq.push_back(0);
        push_norm(16'h0071); lq.push_back(1);
        send_line(16'h0061, 1'b1, 11, 1'b1);
        send_line(16'h0071, 1'b0, 8, 1'b1);
        idle(6);
        check("long_frames", n_frames, 32'd4);
        check("long_drained", wq.size(), 32'd0);

        // sof at pixel 5 of line 1 pads that line, then starts a new frame
        push_norm(16'h0081); lq.push_back(0);
        wq.push_back(32'h0091_0092); wq.push_back(32'h0093_0094);
        wq.push_back(32'h0095_0000); wq.push_back(32'h0); lq.push_back(1);
        push_norm(16'h00A1); lq.push_back(0);
        push_norm(16'h00B1); lq.push_back(1);
        send_line(16'h0081, 1'b1, 8, 1'b1);
        send_line(16'h0091, 1'b0, 5, 1'b0);
        send_line(16'h00A1, 1'b1, 8, 1'b1);
        send_line(16'h00B1, 1'b0, 8, 1'b1);
        idle(6);
        check("sofmid_frames", n_frames, 32'd6);
        check("sofmid_drained", wq.size(), 32'd0);
        check("sofmid_lines", lq.size(), 32'd0);

        // Reset after three pixels: half-packed pixel never reaches the FIFO
        wq.push_back(32'h00C1_00C2);
        send_line(16'h00C1, 1'b1, 3, 1'b0);
        idle(1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        check("mid_rst_line_sync", {31'h0, line_sync}, 32'h0);
        check("mid_rst_frame_sync", {31'h0, frame_sync}, 32'h0);
        check("mid_rst_line_number", {16'h0, line_number}, 32'h0);
        check("mid_rst_err", {31'h0, err_sticky}, 32'h0);
        check("mid_rst_ready", {31'h0, pix_ready}, 32'h1);
        idle(2);
        reset_n = 1'b1;
        idle(4);
        check("mid_rst_drained", wq.size(), 32'd0);
        check("mid_rst_frames", n_frames, 32'd7);

        // Clean frame after reset
        push_norm(16'h00D1); lq.push_back(0);
        push_norm(16'h00E1); lq.push_back(1);
        send_line(16'h00D1, 1'b1, 8, 1'b1);
        send_line(16'h00E1, 1'b0, 8, 1'b1);
        idle(6);
        check("post_rst_frames", n_frames, 32'd8);
        check("post_rst_drained", wq.size(), 32'd0);
        check("post_rst_lines", lq.size(), 32'd0);
        check("post_rst_err", {31'h0, err_sticky}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
